// File: rtl/spm_seq_if.sv
// spm_seq_if: host-side handshake bundle for the spm_seq sequencer.
//
// Signals:
//   in_valid  : operand pair valid (host -> sequencer)
//   in_ready  : sequencer can accept operands (sequencer -> host)
//   x_in      : N-bit signed multiplicand
//   y_in      : N-bit unsigned multiplier
//   out_valid : prod valid (sequencer -> host)
//   out_ready : host accepts prod
//   prod      : 2N-bit signed product
//
// Modports: master = host / register block side, slave = spm_seq side.
interface spm_seq_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x_in;
  logic [N-1:0]   y_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] prod;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/spm_seq.sv
// spm_seq: sequencer and host front end for one spm #(N) serial-parallel
// multiplier. Accepts an operand pair, clears the multiplier for one cycle,
// holds x on spm_x while streaming y LSB-first on spm_y, collects the serial
// product bits from spm_p into a 2N-bit result and returns it over a
// valid/ready handshake.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   host    : spm_seq_if.slave (in_valid/in_ready/x_in/y_in,
//             out_valid/out_ready/prod)
//   busy    : high while an operation is in progress (CLR, RUN, DONE)
//   spm_rst : clear for the attached spm (also high during rst)
//   spm_x   : parallel multiplicand to spm
//   spm_y   : serial multiplier bit to spm
//   spm_p   : serial product bit from spm
module spm_seq #(
  parameter int N     = 8,
  parameter int P_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  spm_seq_if.slave     host,
  output logic         busy,
  output logic         spm_rst,
  output logic [N-1:0] spm_x,
  output logic         spm_y,
  input  logic         spm_p
);

  // Counter must reach 2N+P_LAT-1, the last RUN cycle.
  localparam int LAST = 2 * N + P_LAT - 1;
  localparam int CW   = $clog2(LAST + 2);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   x_reg;
  logic [2*N-1:0] y_sh;
  logic [2*N-1:0] prod_sh;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/control outputs. spm_rst also follows rst so
  // the multiplier stays clear while this block is held in reset.
  always_comb begin
    state_nxt      = state;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    busy           = 1'b1;
    spm_y          = 1'b0;
    spm_rst        = rst;
    case (state)
      IDLE: begin
        host.in_ready = 1'b1;
        busy          = 1'b0;
        if (host.in_valid) begin
          state_nxt = CLR;
        end
      end
      CLR: begin
        spm_rst   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        spm_y = y_sh[0];
        if (cnt == CW'(LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        host.out_valid = 1'b1;
        if (host.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, y shifter, cycle counter and product collector.
  // y is zero-extended to 2N bits so the upper half of the stream feeds
  // zeros while the high product bits drain out of spm. Product capture is
  // delayed by P_LAT so bit k lands when spm presents it; after exactly 2N
  // captures, bit 0 of the product sits in prod_sh[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg   <= '0;
      y_sh    <= '0;
      cnt     <= '0;
      prod_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host.in_valid) begin
            x_reg <= host.x_in;
            y_sh  <= {{N{1'b0}}, host.y_in};
          end
        end
        CLR: begin
          cnt <= '0;
        end
        RUN: begin
          y_sh <= {1'b0, y_sh[2*N-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt >= CW'(P_LAT)) begin
            prod_sh <= {spm_p, prod_sh[2*N-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign spm_x     = x_reg;
  assign host.prod = prod_sh;

endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: self-checking bench for spm_seq with a behavioural spm model
// (one-cycle latency from y bit k to product bit k). Stimulus pushes the
// expected product into a queue; a negedge monitor pops and compares on
// each output handshake and also checks latency, spm_rst pulse count,
// spm_y stream and spm_x stability per operation.
module tb_spm_seq;

  localparam int N     = 8;
  localparam int P_LAT = 1;
  localparam int LAT   = 2 * N + P_LAT + 1;
  localparam int II    = 2 * N + P_LAT + 3;
  localparam int YLEN  = 2 * N + P_LAT;

  logic         clk = 1'b0;
  logic         rst;
  logic         busy;
  logic         spm_rst;
  logic [N-1:0] spm_x;
  logic         spm_y;
  logic         spm_p;

  spm_seq_if #(.N(N)) bus ();

  spm_seq #(.N(N), .P_LAT(P_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (bus),
    .busy    (busy),
    .spm_rst (spm_rst),
    .spm_x   (spm_x),
    .spm_y   (spm_y),
    .spm_p   (spm_p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [2*N-1:0] expQ[$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural spm: accumulates x * y_k * 2^k and emits bit k one cycle
  // after y bit k; later terms never disturb bits already emitted.
  longint spmAcc;
  int     spmK;
  logic   spmP;

  always @(posedge clk) begin : spmModel
    longint nxt;
    if (spm_rst) begin
      spmAcc <= 0;
      spmK   <= 0;
      spmP   <= 1'b0;
    end else begin
      nxt = spmAcc + (spm_y ? (longint'($signed(spm_x)) <<< spmK) : 64'sd0);
      spmAcc <= nxt;
      spmP   <= nxt[spmK];
      if (spmK < 40) spmK <= spmK + 1;
    end
  end

  assign spm_p = spmP;

  // Monitor / scoreboard.
  logic            inFlight = 1'b0;
  logic            opBad    = 1'b0;
  logic            idleBad  = 1'b0;
  logic            prevOv   = 1'b0;
  int              acceptCyc = 0;
  int              rstCnt    = 0;
  int              runIdx    = -1;
  logic [N-1:0]    xCap;
  logic [N-1:0]    yCap;
  logic [YLEN-1:0] ySeen;
  logic [YLEN-1:0] yExp;

  always @(negedge clk) begin
    if (rst) begin
      inFlight = 1'b0;
      runIdx   = -1;
      prevOv   = 1'b0;
    end else begin
      if (inFlight) begin
        if (bus.in_ready !== 1'b0 || busy !== 1'b1 || spm_x !== xCap) opBad = 1'b1;
        if (spm_rst) begin
          rstCnt++;
          runIdx = 0;
        end else if (runIdx >= 0 && runIdx < YLEN) begin
          ySeen[runIdx] = spm_y;
          runIdx++;
        end else if (spm_y !== 1'b0) begin
          opBad = 1'b1;
        end
      end else if (spm_rst !== 1'b0 || spm_y !== 1'b0) begin
        idleBad = 1'b1;
      end

      if (bus.out_valid && !prevOv) begin
        checkOutput("latency", 64'(cyc - acceptCyc), 64'(LAT));
      end

      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected output", 1, 0);
        end else begin
          checkOutput("prod", bus.prod, expQ.pop_front());
        end
        checkOutput("in_ready/busy/spm_x during op", opBad, 0);
        checkOutput("spm_rst pulses", rstCnt, 1);
        yExp = '0;
        yExp[N-1:0] = yCap;
        checkOutput("spm_y stream", ySeen, yExp);
        inFlight = 1'b0;
      end

      if (bus.in_valid && bus.in_ready) begin
        inFlight  = 1'b1;
        opBad     = 1'b0;
        rstCnt    = 0;
        runIdx    = -1;
        ySeen     = '0;
        xCap      = bus.x_in;
        yCap      = bus.y_in;
        acceptCyc = cyc + 1;
      end
      prevOv = bus.out_valid;
    end
  end

  // Present an operand pair and hold in_valid until accepted; returns the
  // cycle number of the accepting edge. in_valid is left high.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic [2*N-1:0] exp, output int accCyc);
    bus.x_in     = x;
    bus.y_in     = y;
    bus.in_valid = 1'b1;
    expQ.push_back(exp);
    accCyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        accCyc = cyc;
        break;
      end
    end
    if (accCyc < 0) checkOutput("accept timeout", 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1;
    int a2;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_in      = '0;
    bus.y_in      = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", bus.in_ready, 1);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset prod", bus.prod, 0);
    checkOutput("reset spm_x", spm_x, 0);
    checkOutput("reset spm_y", spm_y, 0);
    checkOutput("reset spm_rst", spm_rst, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("spm_rst after reset", spm_rst, 0);

    // Basic product and latency.
    applyStimulus(8'd50, 8'd50, 16'd2500, a1);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high.
    applyStimulus(8'd25, 8'd65, 16'd1625, a1);
    applyStimulus(8'd80, 8'd9, 16'd720, a2);
    checkOutput("initiation interval", 64'(a2 - a1), 64'(II));
    bus.in_valid = 1'b0;
    drain();

    // Signed multiplicand.
    applyStimulus(8'hF7, 8'd80, 16'hFD30, a1);
    bus.in_valid = 1'b0;
    drain();
    applyStimulus(8'h80, 8'd255, 16'h8080, a1);
    bus.in_valid = 1'b0;
    drain();

    // Output stall in DONE with in_valid ignored.
    bus.out_ready = 1'b0;
    applyStimulus(8'd3, 8'd7, 16'd21, a1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    bus.x_in     = 8'd5;
    bus.y_in     = 8'd5;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall out_valid", bus.out_valid, 1);
      checkOutput("stall prod", bus.prod, 16'd21);
      checkOutput("stall in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release in_ready", bus.in_ready, 1);
    checkOutput("release out_valid", bus.out_valid, 0);

    // Reset mid-RUN at cnt=5, then a clean operation.
    applyStimulus(8'd100, 8'd100, 16'd10000, a1);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort out_valid", bus.out_valid, 0);
    checkOutput("abort in_ready", bus.in_ready, 1);
    checkOutput("abort spm_rst", spm_rst, 1);
    checkOutput("abort busy", busy, 0);
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'd9, 8'd80, 16'd720, a1);
    bus.in_valid = 1'b0;
    drain();

    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("idle spm_rst/spm_y quiet", idleBad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
